// File: rtl/alien_pkg.sv
// Shared types and constants for the alien sprite engines.
package alien_pkg;

   typedef enum logic [2:0] {
      RIGHT,
      LEFT,
      DOWN_L,
      DOWN_R,
      LANDED
   } move_state_t;

   localparam logic [7:0] TRANSPARENT = 8'h00;
   localparam int         H_ACTIVE    = 640;
   localparam int         V_ACTIVE    = 480;

endpackage

// File: rtl/alien_mover.sv
// Frame-paced marching logic: divider, move FSM and the sprite's top-left position.
module alien_mover
   import alien_pkg::*;
#(
   parameter int         SPR_W    = 31,
   parameter logic [9:0] START_X  = 10'd32,
   parameter logic [9:0] START_Y  = 10'd48,
   parameter logic [9:0] X_MIN    = 10'd0,
   parameter logic [9:0] X_MAX    = 10'd639,
   parameter logic [9:0] Y_LAND   = 10'd400,
   parameter logic [9:0] STEP_X   = 10'd2,
   parameter logic [9:0] STEP_Y   = 10'd16,
   parameter int         MOVE_DIV = 4
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic       frame_tick,
   output logic [9:0] alien_x,
   output logic [9:0] alien_y,
   output logic       landed
);

   localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

   move_state_t state;
   logic [3:0]  frame_div;
   logic [10:0] right_edge;
   logic [10:0] y_dropped;
   logic        room_right;
   logic        room_left;
   logic        hits_ground;

   // All edge tests are done in 11 bits so a step can never wrap past the compare.
   always_comb begin
      right_edge  = {1'b0, alien_x} + {1'b0, STEP_X} + 11'(SPR_W - 1);
      room_right  = right_edge <= {1'b0, X_MAX};
      room_left   = {1'b0, alien_x} >= ({1'b0, X_MIN} + {1'b0, STEP_X});
      y_dropped   = {1'b0, alien_y} + {1'b0, STEP_Y};
      hits_ground = y_dropped >= {1'b0, Y_LAND};
   end

   // Position only changes on a move tick, so it is frozen for the whole of active video.
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         state     <= RIGHT;
         frame_div <= '0;
         alien_x   <= START_X;
         alien_y   <= START_Y;
         landed    <= 1'b0;
      end else if (frame_tick) begin
         if (frame_div == DIV_LAST) begin
            frame_div <= '0;
            case (state)
               RIGHT: begin
                  if (room_right) alien_x <= alien_x + STEP_X;
                  else            state   <= DOWN_L;
               end
               LEFT: begin
                  if (room_left) alien_x <= alien_x - STEP_X;
                  else           state   <= DOWN_R;
               end
               DOWN_L, DOWN_R: begin
                  alien_y <= y_dropped[9:0];
                  if (hits_ground) begin
                     state  <= LANDED;
                     landed <= 1'b1;
                  end else begin
                     state <= (state == DOWN_L) ? LEFT : RIGHT;
                  end
               end
               LANDED: state <= LANDED;
               default: state <= RIGHT;
            endcase
         end else begin
            frame_div <= frame_div + 4'd1;
         end
      end
   end

endmodule

// File: rtl/alien2_sprite.sv
// Alien2 sprite engine: ROM addressing from the scan position and a 3-clock pixel pipeline.
module alien2_sprite
   import alien_pkg::*;
#(
   parameter int         SPR_W    = 31,
   parameter int         SPR_H    = 21,
   parameter logic [9:0] START_X  = 10'd32,
   parameter logic [9:0] START_Y  = 10'd48,
   parameter logic [9:0] X_MIN    = 10'd0,
   parameter logic [9:0] X_MAX    = 10'd639,
   parameter logic [9:0] Y_LAND   = 10'd400,
   parameter logic [9:0] STEP_X   = 10'd2,
   parameter logic [9:0] STEP_Y   = 10'd16,
   parameter int         MOVE_DIV = 4
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic [9:0] xx,
   input  logic [9:0] yy,
   input  logic       aactive,
   input  logic       frame_tick,
   output logic [9:0] A2address,
   input  logic [7:0] A2dout,
   output logic [7:0] alien_pix,
   output logic       alien_on,
   output logic [9:0] alien_x,
   output logic [9:0] alien_y,
   output logic       landed
);

   logic        in_box;
   logic        box_d1;
   logic        box_d2;
   logic [9:0]  dx;
   logic [9:0]  dy;
   logic [9:0]  addr_next;
   logic        opaque;

   alien_mover #(
      .SPR_W    (SPR_W),
      .START_X  (START_X),
      .START_Y  (START_Y),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX),
      .Y_LAND   (Y_LAND),
      .STEP_X   (STEP_X),
      .STEP_Y   (STEP_Y),
      .MOVE_DIV (MOVE_DIV)
   ) u_mover (
      .clk_pix    (clk_pix),
      .reset      (reset),
      .frame_tick (frame_tick),
      .alien_x    (alien_x),
      .alien_y    (alien_y),
      .landed     (landed)
   );

   // Box bounds are widened to 11 bits so a sprite near the right/bottom edge cannot wrap.
   always_comb begin
      in_box = aactive
            && ({1'b0, xx} >= {1'b0, alien_x})
            && ({1'b0, xx} <  ({1'b0, alien_x} + 11'(SPR_W)))
            && ({1'b0, yy} >= {1'b0, alien_y})
            && ({1'b0, yy} <  ({1'b0, alien_y} + 11'(SPR_H)));
      dx        = xx - alien_x;
      dy        = yy - alien_y;
      addr_next = in_box ? 10'(dy * 10'(SPR_W) + dx) : 10'd0;
      opaque    = box_d2 && (A2dout != TRANSPARENT);
   end

   // The box flag travels alongside the ROM read so it lines up with A2dout.
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         A2address <= '0;
         box_d1    <= 1'b0;
         box_d2    <= 1'b0;
         alien_pix <= TRANSPARENT;
         alien_on  <= 1'b0;
      end else begin
         A2address <= addr_next;
         box_d1    <= in_box;
         box_d2    <= box_d1;
         alien_pix <= opaque ? A2dout : TRANSPARENT;
         alien_on  <= opaque;
      end
   end

endmodule

// File: tb/tb_alien2_sprite.sv
// Randomised self-checking bench for alien2_sprite against a behavioural march/scan model.
module tb_alien2_sprite;

   logic       clk_pix = 1'b0;
   logic       reset;
   logic [9:0] xx;
   logic [9:0] yy;
   logic       aactive;
   logic       frame_tick;
   logic [9:0] A2address;
   logic [7:0] A2dout;
   logic [7:0] alien_pix;
   logic       alien_on;
   logic [9:0] alien_x;
   logic [9:0] alien_y;
   logic       landed;

   int checks = 0;
   int errors = 0;

   logic [7:0] rom [0:1023];

   // Model state: position, march direction, pending drop, landing and frame divider.
   int m_x, m_y, m_dir, m_div;
   bit m_drop, m_landed;
   int h_in   [3];
   int h_addr [3];

   alien2_sprite dut (
      .clk_pix    (clk_pix),
      .reset      (reset),
      .xx         (xx),
      .yy         (yy),
      .aactive    (aactive),
      .frame_tick (frame_tick),
      .A2address  (A2address),
      .A2dout     (A2dout),
      .alien_pix  (alien_pix),
      .alien_on   (alien_on),
      .alien_x    (alien_x),
      .alien_y    (alien_y),
      .landed     (landed)
   );

   always #20 clk_pix = ~clk_pix;

   always @(posedge clk_pix) A2dout <= rom[A2address];

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, actual, actual, expected, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_x = 32; m_y = 48; m_dir = 1; m_div = 0;
      m_drop = 0; m_landed = 0;
      for (int i = 0; i < 3; i++) begin
         h_in[i] = 0;
         h_addr[i] = 0;
      end
   endtask

   task automatic modelMove();
      if (m_landed) return;
      if (m_drop) begin
         m_y += 16;
         m_drop = 0;
         if (m_y >= 400) m_landed = 1;
         else            m_dir = -m_dir;
      end else if (m_dir > 0) begin
         if (m_x + 2 + 30 <= 639) m_x += 2;
         else                     m_drop = 1;
      end else begin
         if (m_x >= 2) m_x -= 2;
         else          m_drop = 1;
      end
   endtask

   task automatic modelTick();
      if (m_div == 3) begin
         m_div = 0;
         modelMove();
      end else begin
         m_div++;
      end
   endtask

   // One clock: drive inputs, let the edge pass, then compare every output to the model.
   task automatic applyStimulus(input int sx, input int sy, input bit act,
                                input bit tick, input bit rst);
      int  e_in, e_addr, e_pix;
      xx = 10'(sx); yy = 10'(sy); aactive = act; frame_tick = tick; reset = rst;
      e_in = (!rst && act && sx >= m_x && sx < m_x + 31 && sy >= m_y && sy < m_y + 21) ? 1 : 0;
      e_addr = e_in ? (sy - m_y) * 31 + (sx - m_x) : 0;
      @(posedge clk_pix);
      #1;
      if (rst) begin
         modelReset();
      end else begin
         if (tick) modelTick();
         h_in[2] = h_in[1];   h_addr[2] = h_addr[1];
         h_in[1] = h_in[0];   h_addr[1] = h_addr[0];
         h_in[0] = e_in;      h_addr[0] = e_addr;
      end
      e_pix = h_in[2] ? int'(rom[h_addr[2]]) : 0;
      checkOutput("address",   int'(A2address), e_addr);
      checkOutput("alien_pix", int'(alien_pix), e_pix);
      checkOutput("alien_on",  int'(alien_on),  (e_pix != 0) ? 1 : 0);
      checkOutput("alien_x",   int'(alien_x),   m_x);
      checkOutput("alien_y",   int'(alien_y),   m_y);
      checkOutput("landed",    int'(landed),    m_landed ? 1 : 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic randomScan(input bit tick);
      int sx, sy;
      sx = m_x + int'($urandom_range(0, 40)) - 5;
      sy = m_y + int'($urandom_range(0, 28)) - 4;
      if (sx < 0) sx = 0;
      if (sy < 0) sy = 0;
      applyStimulus(sx, sy, ($urandom_range(0, 7) != 0), tick, 0);
   endtask

   int hold_x, hold_y;

   initial begin
      for (int i = 0; i < 1024; i++)
         rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rom[0]   = 8'h1C;
      rom[5]   = 8'h00;
      rom[650] = 8'h5A;
      xx = 0; yy = 0; aactive = 0; frame_tick = 0; reset = 1;
      modelReset();

      applyStimulus(32, 48, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("reset_x", int'(alien_x), 32);
      checkOutput("reset_y", int'(alien_y), 48);

      // Top-left pixel: address 0, ROM value shows up three clocks after the scan.
      applyStimulus(32, 48, 1, 0, 0);
      checkOutput("tl_addr", int'(A2address), 0);
      idle(2);
      checkOutput("tl_pix", int'(alien_pix), 8'h1C);
      checkOutput("tl_on",  int'(alien_on), 1);

      // Bottom-right corner and the column just past it.
      applyStimulus(62, 68, 1, 0, 0);
      checkOutput("corner_addr", int'(A2address), 650);
      applyStimulus(63, 68, 1, 0, 0);
      checkOutput("past_corner_addr", int'(A2address), 0);
      idle(1);
      checkOutput("corner_pix", int'(alien_pix), 8'h5A);
      idle(1);
      checkOutput("past_corner_on", int'(alien_on), 0);

      // Transparent ROM value inside the box.
      applyStimulus(37, 48, 1, 0, 0);
      idle(2);
      checkOutput("transp_on",  int'(alien_on), 0);
      checkOutput("transp_pix", int'(alien_pix), 0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
         idle(1);
      end
      checkOutput("x_after_8_ticks", int'(alien_x), 36);
      checkOutput("y_after_8_ticks", int'(alien_y), 48);

      for (int i = 0; i < 300; i++) randomScan($urandom_range(0, 9) == 0);

      // March all the way to the ground with a tick every clock.
      for (int c = 0; c < 40000 && !m_landed; c++) randomScan(1);
      checkOutput("landed_reached", int'(landed), 1);
      checkOutput("landed_y", int'(alien_y), 400);

      hold_x = m_x;
      hold_y = m_y;
      for (int i = 0; i < 24; i++) randomScan(1);
      checkOutput("landed_hold_x", int'(alien_x), hold_x);
      checkOutput("landed_hold_y", int'(alien_y), hold_y);

      // Reset in the middle of an in-box scan burst.
      applyStimulus(m_x + 3, m_y + 2, 1, 0, 0);
      applyStimulus(m_x + 4, m_y + 2, 1, 1, 1);
      checkOutput("midreset_landed", int'(landed), 0);
      checkOutput("midreset_x", int'(alien_x), 32);
      checkOutput("midreset_y", int'(alien_y), 48);
      checkOutput("midreset_on", int'(alien_on), 0);
      for (int i = 0; i < 40; i++) randomScan($urandom_range(0, 3) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
